tl_a_arb_2: RTL and testbench
=============================

TL_A_ARB_2 -- requirements
Module: tl_a_arb_2

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4, range 1..7: maximum outstanding A requests per client.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_in_N_valid  in  1  client N (N=0,1) request valid.
REQ-005 io_in_N_ready  out  1  client N request accepted this cycle.
REQ-006 io_in_N_bits_opcode/param  in  3/3  TL-A opcode and param of client N.
REQ-007 io_in_N_bits_size  in  2  log2 bytes, 0..3.
REQ-008 io_in_N_bits_source  in  9  client-local source ID.
REQ-009 io_in_N_bits_address/mask/data  in  32/8/64  TL-A address, byte mask and data.
REQ-010 io_out_valid/io_out_ready  out/in  1/1  merged A stream, handshake with the downstream 2-entry A queue.
REQ-011 io_out_bits_opcode/param/size/address/mask/data  out  3/3/2/32/8/64  forwarded fields of the granted client.
REQ-012 io_out_bits_source  out  10  {grant index, client source}.
REQ-013 io_ack_valid  in  1  D-channel response retired this cycle.
REQ-014 io_ack_source  in  10  source of the retired response; bit 9 selects the client.
REQ-015 io_inflight_N  out  3  current outstanding count of client N.
REQ-016 io_err  out  1  sticky protocol-error flag.

Function
REQ-017 eligible_N SHALL be io_in_N_valid AND inflight_N < MAX_INFLIGHT.
REQ-018 When unlocked, grant SHALL go to the only eligible client; if both are eligible, grant SHALL go to the client other than last_grant (round-robin).
REQ-019 When locked, grant SHALL be lock_idx regardless of the other client.
REQ-020 io_out_valid SHALL be io_in_{grant}_valid when locked, else OR of eligible_0 and eligible_1; combinational, zero added latency.
REQ-021 io_in_N_ready SHALL be io_out_ready AND io_out_valid AND grant==N; it SHALL be 0 for the non-granted client.
REQ-022 io_out_bits_* SHALL equal the granted client's fields; io_out_bits_source[9] SHALL equal grant and [8:0] the client source.
REQ-023 fire = io_out_valid AND io_out_ready; on fire, last_grant SHALL take grant and locked SHALL clear.
REQ-024 On io_out_valid AND NOT io_out_ready, locked SHALL set and lock_idx SHALL take grant, so the presented beat stays stable until it fires.
REQ-025 If the locked client drops valid before fire, locked SHALL clear next cycle and io_err SHALL set.
REQ-026 inflight_N SHALL increment on a fire from N and decrement on io_ack_valid with io_ack_source[9]==N; if both occur in the same cycle it SHALL be unchanged.
REQ-027 An ack to a client with inflight 0 SHALL leave the count at 0 and set io_err; the count SHALL never exceed MAX_INFLIGHT.
REQ-028 io_err SHALL remain 1 until reset.
REQ-029 A client at MAX_INFLIGHT SHALL be skipped, not waited on; the other client SHALL be granted in the same cycle.

Reset
REQ-030 While reset is high, registers SHALL take: inflight_0/1=0, last_grant=1, locked=0, lock_idx=0, io_err=0.
REQ-031 During reset, io_out_valid and io_in_N_ready are don't-care; the first cycle after reset, client 0 SHALL win a tie.
REQ-032 Reset asserted mid-lock SHALL drop the lock with no beat issued from the lock state; the in-flight counts SHALL be lost.

Verification
REQ-033 Tie: both valid, out_ready=1 for 4 cycles -> grants 0,1,0,1; out_source[9] follows; inflight_0=2, inflight_1=2.
REQ-034 Stall: client 1 granted, out_ready=0 for 3 cycles, client 0 raises valid -> out bits stay client 1's, in_0_ready=0; client 1 fires on the ready cycle, then client 0 is granted.
REQ-035 Limit: MAX_INFLIGHT=4, client 0 fires 4 times with no ack -> 5th request not granted, client 1 served alone; one ack with source 0x0xx -> client 0 eligible the next cycle.
REQ-036 Same-cycle: client 1 fire plus ack source 0x2xx -> inflight_1 unchanged.
REQ-037 Errors: ack to client with inflight 0 -> io_err=1 and count stays 0; locked client drops valid -> io_err=1 and the lock clears; io_err holds until reset.
REQ-038 Reset: reset pulse with inflight_0=3 and locked=1 -> all counts 0, io_err=0, first tie goes to client 0.

Source files
------------

// File: rtl/tl_a_arb_2.sv
// tl_a_arb_2: two-client TileLink A-channel arbiter.
//
// Merges two A request streams onto one output with round-robin fairness.
// It keeps a per-client outstanding-request count so that a client with
// MAX_INFLIGHT requests outstanding is skipped. A beat presented while
// downstream is stalled is held until it fires. Protocol violations latch
// into a sticky error flag: a held client dropping valid, or a response
// arriving for a client with nothing outstanding.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_OPEN  | no beat pending; grant chosen from eligible clients
// ST_HELD  | beat presented but not accepted; grant pinned to lock_idx

module tl_a_arb_2 #(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        io_in_0_valid,
   output logic        io_in_0_ready,
   input  logic [2:0]  io_in_0_bits_opcode,
   input  logic [2:0]  io_in_0_bits_param,
   input  logic [1:0]  io_in_0_bits_size,
   input  logic [8:0]  io_in_0_bits_source,
   input  logic [31:0] io_in_0_bits_address,
   input  logic [7:0]  io_in_0_bits_mask,
   input  logic [63:0] io_in_0_bits_data,

   input  logic        io_in_1_valid,
   output logic        io_in_1_ready,
   input  logic [2:0]  io_in_1_bits_opcode,
   input  logic [2:0]  io_in_1_bits_param,
   input  logic [1:0]  io_in_1_bits_size,
   input  logic [8:0]  io_in_1_bits_source,
   input  logic [31:0] io_in_1_bits_address,
   input  logic [7:0]  io_in_1_bits_mask,
   input  logic [63:0] io_in_1_bits_data,

   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [2:0]  io_out_bits_opcode,
   output logic [2:0]  io_out_bits_param,
   output logic [1:0]  io_out_bits_size,
   output logic [9:0]  io_out_bits_source,
   output logic [31:0] io_out_bits_address,
   output logic [7:0]  io_out_bits_mask,
   output logic [63:0] io_out_bits_data,

   input  logic        io_ack_valid,
   input  logic [9:0]  io_ack_source,

   output logic [2:0]  io_inflight_0,
   output logic [2:0]  io_inflight_1,
   output logic        io_err
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

   typedef enum logic {
      ST_OPEN = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic       lock_idx_q, lock_idx_d;
   logic       last_grant_q, last_grant_d;
   logic       err_q, err_d;
   logic [2:0] inflight_0_q, inflight_0_d;
   logic [2:0] inflight_1_q, inflight_1_d;

   logic       elig_0, elig_1;
   logic       grant;
   logic       fire;
   logic       lock_drop;
   logic       inc_0, inc_1, dec_0, dec_1;
   logic       under_0, under_1;

   // The response tag below the client-select bit identifies the request
   // inside the client and carries no meaning for the arbiter.
   logic       ack_tag_unused;
   assign ack_tag_unused = ^io_ack_source[8:0];

   // Saturating up/down count; a simultaneous increment and decrement cancel.
   function automatic logic [2:0] count_next(input logic [2:0] cnt,
                                             input logic       inc,
                                             input logic       dec);
      logic [2:0] res;
      res = cnt;
      if (inc && !dec) begin
         if (cnt < MAX_CNT) res = cnt + 3'd1;
      end else if (dec && !inc) begin
         if (cnt != 3'd0) res = cnt - 3'd1;
      end
      return res;
   endfunction

   // Grant selection: pinned while held, otherwise round-robin among eligible clients.
   always_comb begin
      elig_0       = io_in_0_valid && (inflight_0_q < MAX_CNT);
      elig_1       = io_in_1_valid && (inflight_1_q < MAX_CNT);
      grant        = 1'b0;
      io_out_valid = 1'b0;
      if (state_q == ST_HELD) begin
         grant        = lock_idx_q;
         io_out_valid = lock_idx_q ? io_in_1_valid : io_in_0_valid;
      end else begin
         if (elig_0 && elig_1) begin
            grant = ~last_grant_q;
         end else if (elig_1) begin
            grant = 1'b1;
         end
         io_out_valid = elig_0 || elig_1;
      end
   end

   assign fire          = io_out_valid && io_out_ready;
   assign io_in_0_ready = fire && (grant == 1'b0);
   assign io_in_1_ready = fire && (grant == 1'b1);

   // Forward the granted client's fields; the client index tags the source.
   always_comb begin
      io_out_bits_opcode  = io_in_0_bits_opcode;
      io_out_bits_param   = io_in_0_bits_param;
      io_out_bits_size    = io_in_0_bits_size;
      io_out_bits_source  = {1'b0, io_in_0_bits_source};
      io_out_bits_address = io_in_0_bits_address;
      io_out_bits_mask    = io_in_0_bits_mask;
      io_out_bits_data    = io_in_0_bits_data;
      if (grant) begin
         io_out_bits_opcode  = io_in_1_bits_opcode;
         io_out_bits_param   = io_in_1_bits_param;
         io_out_bits_size    = io_in_1_bits_size;
         io_out_bits_source  = {1'b1, io_in_1_bits_source};
         io_out_bits_address = io_in_1_bits_address;
         io_out_bits_mask    = io_in_1_bits_mask;
         io_out_bits_data    = io_in_1_bits_data;
      end
   end

   // Lock FSM next state: hold a stalled beat, release on fire or on a valid drop.
   always_comb begin
      state_d      = state_q;
      lock_idx_d   = lock_idx_q;
      last_grant_d = last_grant_q;
      lock_drop    = 1'b0;
      case (state_q)
         ST_OPEN: begin
            if (fire) begin
               last_grant_d = grant;
            end else if (io_out_valid) begin
               state_d    = ST_HELD;
               lock_idx_d = grant;
            end
         end
         ST_HELD: begin
            if (fire) begin
               state_d      = ST_OPEN;
               last_grant_d = grant;
            end else if (!io_out_valid) begin
               state_d   = ST_OPEN;
               lock_drop = 1'b1;
            end
         end
         default: state_d = ST_OPEN;
      endcase
   end

   // Outstanding counts and the sticky error flag.
   always_comb begin
      inc_0        = fire && (grant == 1'b0);
      inc_1        = fire && (grant == 1'b1);
      dec_0        = io_ack_valid && (io_ack_source[9] == 1'b0);
      dec_1        = io_ack_valid && (io_ack_source[9] == 1'b1);
      under_0      = dec_0 && !inc_0 && (inflight_0_q == 3'd0);
      under_1      = dec_1 && !inc_1 && (inflight_1_q == 3'd0);
      inflight_0_d = count_next(inflight_0_q, inc_0, dec_0);
      inflight_1_d = count_next(inflight_1_q, inc_1, dec_1);
      err_d        = err_q || lock_drop || under_0 || under_1;
   end

   // State register with synchronous reset; reset drops any held beat and all counts.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_OPEN;
         lock_idx_q   <= 1'b0;
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
         inflight_0_q <= 3'd0;
         inflight_1_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         lock_idx_q   <= lock_idx_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         inflight_0_q <= inflight_0_d;
         inflight_1_q <= inflight_1_d;
      end
   end

   assign io_inflight_0 = inflight_0_q;
   assign io_inflight_1 = inflight_1_q;
   assign io_err        = err_q;

endmodule

// File: tb/tb_tl_a_arb_2.sv
// Testbench for tl_a_arb_2: a directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a transaction-level
// reference model of the arbitration and accounting rules.

module tb_tl_a_arb_2;

   localparam int MAX = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_in_0_valid, io_in_0_ready;
   logic [2:0]  io_in_0_bits_opcode, io_in_0_bits_param;
   logic [1:0]  io_in_0_bits_size;
   logic [8:0]  io_in_0_bits_source;
   logic [31:0] io_in_0_bits_address;
   logic [7:0]  io_in_0_bits_mask;
   logic [63:0] io_in_0_bits_data;
   logic        io_in_1_valid, io_in_1_ready;
   logic [2:0]  io_in_1_bits_opcode, io_in_1_bits_param;
   logic [1:0]  io_in_1_bits_size;
   logic [8:0]  io_in_1_bits_source;
   logic [31:0] io_in_1_bits_address;
   logic [7:0]  io_in_1_bits_mask;
   logic [63:0] io_in_1_bits_data;
   logic        io_out_valid, io_out_ready;
   logic [2:0]  io_out_bits_opcode, io_out_bits_param;
   logic [1:0]  io_out_bits_size;
   logic [9:0]  io_out_bits_source;
   logic [31:0] io_out_bits_address;
   logic [7:0]  io_out_bits_mask;
   logic [63:0] io_out_bits_data;
   logic        io_ack_valid;
   logic [9:0]  io_ack_source;
   logic [2:0]  io_inflight_0, io_inflight_1;
   logic        io_err;

   tl_a_arb_2 #(.MAX_INFLIGHT(MAX)) dut (
      .clock(clock), .reset(reset),
      .io_in_0_valid(io_in_0_valid), .io_in_0_ready(io_in_0_ready),
      .io_in_0_bits_opcode(io_in_0_bits_opcode), .io_in_0_bits_param(io_in_0_bits_param),
      .io_in_0_bits_size(io_in_0_bits_size), .io_in_0_bits_source(io_in_0_bits_source),
      .io_in_0_bits_address(io_in_0_bits_address), .io_in_0_bits_mask(io_in_0_bits_mask),
      .io_in_0_bits_data(io_in_0_bits_data),
      .io_in_1_valid(io_in_1_valid), .io_in_1_ready(io_in_1_ready),
      .io_in_1_bits_opcode(io_in_1_bits_opcode), .io_in_1_bits_param(io_in_1_bits_param),
      .io_in_1_bits_size(io_in_1_bits_size), .io_in_1_bits_source(io_in_1_bits_source),
      .io_in_1_bits_address(io_in_1_bits_address), .io_in_1_bits_mask(io_in_1_bits_mask),
      .io_in_1_bits_data(io_in_1_bits_data),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_out_bits_opcode(io_out_bits_opcode), .io_out_bits_param(io_out_bits_param),
      .io_out_bits_size(io_out_bits_size), .io_out_bits_source(io_out_bits_source),
      .io_out_bits_address(io_out_bits_address), .io_out_bits_mask(io_out_bits_mask),
      .io_out_bits_data(io_out_bits_data),
      .io_ack_valid(io_ack_valid), .io_ack_source(io_ack_source),
      .io_inflight_0(io_inflight_0), .io_inflight_1(io_inflight_1),
      .io_err(io_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: outstanding counts, fairness pointer, pending beat, error
   int m_infl[2];
   int m_last;
   bit m_held;
   int m_idx;
   bit m_err;
   // inputs of the current cycle and the model's prediction for it
   bit c_v[2];
   bit c_rdy, c_ackv;
   logic [9:0] c_acks;
   bit e_ov;
   int e_g;

   typedef struct {
      bit v0; bit v1; bit rdy; bit ackv; logic [9:0] acks;
      bit ov; bit g; int i0; int i1; bit err;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_infl[0] = 0; m_infl[1] = 0;
      m_last = 1; m_held = 0; m_idx = 0; m_err = 0;
   endtask

   task automatic model_predict();
      bit el[2];
      if (m_held) begin
         e_g  = m_idx;
         e_ov = c_v[m_idx];
      end else begin
         for (int n = 0; n < 2; n++) el[n] = c_v[n] && (m_infl[n] < MAX);
         if (el[0] && el[1]) e_g = 1 - m_last;
         else if (el[1])     e_g = 1;
         else                e_g = 0;
         e_ov = el[0] || el[1];
      end
   endtask

   task automatic model_update();
      bit fire;
      bit inc, dec;
      fire = e_ov && c_rdy;
      for (int n = 0; n < 2; n++) begin
         inc = fire && (e_g == n);
         dec = c_ackv && (int'(c_acks[9]) == n);
         if (inc && !dec && m_infl[n] < MAX) m_infl[n]++;
         if (dec && !inc) begin
            if (m_infl[n] == 0) m_err = 1;
            else m_infl[n]--;
         end
      end
      if (fire) begin
         m_last = e_g; m_held = 0;
      end else if (e_ov) begin
         m_held = 1; m_idx = e_g;
      end else if (m_held) begin
         m_held = 0; m_err = 1;
      end
   endtask

   function automatic logic [127:0] exp_bits(input int g);
      if (g == 1)
         return {6'd0, io_in_1_bits_opcode, io_in_1_bits_param, io_in_1_bits_size, 1'b1,
                 io_in_1_bits_source, io_in_1_bits_address, io_in_1_bits_mask, io_in_1_bits_data};
      return {6'd0, io_in_0_bits_opcode, io_in_0_bits_param, io_in_0_bits_size, 1'b0,
              io_in_0_bits_source, io_in_0_bits_address, io_in_0_bits_mask, io_in_0_bits_data};
   endfunction

   task automatic model_check();
      chk("m_out_valid", io_out_valid, e_ov);
      chk("m_in0_ready", io_in_0_ready, e_ov && c_rdy && e_g == 0);
      chk("m_in1_ready", io_in_1_ready, e_ov && c_rdy && e_g == 1);
      chk("m_inflight0", io_inflight_0, m_infl[0]);
      chk("m_inflight1", io_inflight_1, m_infl[1]);
      chk("m_err", io_err, m_err);
      if (e_ov)
         chk("m_out_bits", {6'd0, io_out_bits_opcode, io_out_bits_param, io_out_bits_size,
             io_out_bits_source, io_out_bits_address, io_out_bits_mask, io_out_bits_data},
             exp_bits(e_g));
   endtask

   task automatic setin(input bit v0, input bit v1, input bit rdy, input bit ackv,
                        input logic [9:0] acks);
      io_in_0_valid = v0; io_in_1_valid = v1; io_out_ready = rdy;
      io_ack_valid = ackv; io_ack_source = acks;
      c_v[0] = v0; c_v[1] = v1; c_rdy = rdy; c_ackv = ackv; c_acks = acks;
   endtask

   task automatic settle();
      #4;
      model_predict();
   endtask

   task automatic adv();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic cyc(input bit v0, input bit v1, input bit rdy, input bit ackv,
                      input logic [9:0] acks);
      setin(v0, v1, rdy, ackv, acks);
      settle();
      model_check();
      adv();
   endtask

   task automatic do_reset();
      setin(0, 0, 0, 0, 10'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic fixed_fields();
      io_in_0_bits_opcode = 3'd4; io_in_0_bits_param = 3'd1; io_in_0_bits_size = 2'd3;
      io_in_0_bits_source = 9'h011; io_in_0_bits_address = 32'h1000_0040;
      io_in_0_bits_mask = 8'hFF; io_in_0_bits_data = 64'h0123_4567_89AB_CDEF;
      io_in_1_bits_opcode = 3'd0; io_in_1_bits_param = 3'd2; io_in_1_bits_size = 2'd2;
      io_in_1_bits_source = 9'h1A5; io_in_1_bits_address = 32'h2000_0080;
      io_in_1_bits_mask = 8'h0F; io_in_1_bits_data = 64'hFEDC_BA98_7654_3210;
   endtask

   task automatic rand_fields();
      io_in_0_bits_opcode = 3'($urandom); io_in_0_bits_param = 3'($urandom);
      io_in_0_bits_size = 2'($urandom); io_in_0_bits_source = 9'($urandom);
      io_in_0_bits_address = $urandom; io_in_0_bits_mask = 8'($urandom);
      io_in_0_bits_data = {$urandom, $urandom};
      io_in_1_bits_opcode = 3'($urandom); io_in_1_bits_param = 3'($urandom);
      io_in_1_bits_size = 2'($urandom); io_in_1_bits_source = 9'($urandom);
      io_in_1_bits_address = $urandom; io_in_1_bits_mask = 8'($urandom);
      io_in_1_bits_data = {$urandom, $urandom};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // v0 v1 rdy ackv acks | ov g i0 i1 err (sampled before the edge)
      tbl[0]  = '{1, 1, 1, 0, 10'h000, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 0, 10'h000, 1, 1, 1, 0, 0};
      tbl[2]  = '{1, 1, 1, 0, 10'h000, 1, 0, 1, 1, 0};
      tbl[3]  = '{1, 1, 1, 0, 10'h000, 1, 1, 2, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 10'h000, 0, 0, 2, 2, 0};
      tbl[5]  = '{0, 1, 0, 0, 10'h000, 1, 1, 2, 2, 0};
      tbl[6]  = '{1, 1, 0, 0, 10'h000, 1, 1, 2, 2, 0};
      tbl[7]  = '{1, 1, 0, 0, 10'h000, 1, 1, 2, 2, 0};
      tbl[8]  = '{1, 1, 1, 0, 10'h000, 1, 1, 2, 2, 0};
      tbl[9]  = '{1, 0, 1, 0, 10'h000, 1, 0, 2, 3, 0};
      tbl[10] = '{0, 0, 1, 1, 10'h200, 0, 0, 3, 3, 0};
      tbl[11] = '{0, 0, 1, 1, 10'h005, 0, 0, 3, 2, 0};
      tbl[12] = '{0, 1, 1, 1, 10'h2AB, 1, 1, 2, 2, 0};
      tbl[13] = '{0, 0, 0, 0, 10'h000, 0, 0, 2, 2, 0};

      fixed_fields();
      setin(0, 0, 0, 0, 10'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      do_reset();

      // directed table: tie rotation, stall hold, same-cycle fire+ack
      for (int i = 0; i < 14; i++) begin
         setin(tbl[i].v0, tbl[i].v1, tbl[i].rdy, tbl[i].ackv, tbl[i].acks);
         settle();
         chk($sformatf("tbl%0d_valid", i), io_out_valid, tbl[i].ov);
         if (tbl[i].ov) chk($sformatf("tbl%0d_grant", i), io_out_bits_source[9], tbl[i].g);
         chk($sformatf("tbl%0d_ready0", i), io_in_0_ready, tbl[i].ov && tbl[i].rdy && !tbl[i].g);
         chk($sformatf("tbl%0d_ready1", i), io_in_1_ready, tbl[i].ov && tbl[i].rdy && tbl[i].g);
         chk($sformatf("tbl%0d_infl0", i), io_inflight_0, tbl[i].i0);
         chk($sformatf("tbl%0d_infl1", i), io_inflight_1, tbl[i].i1);
         chk($sformatf("tbl%0d_err", i), io_err, tbl[i].err);
         model_check();
         adv();
      end

      // limit: client 0 saturates, client 1 served alone, one ack reopens client 0
      do_reset();
      repeat (4) cyc(1, 0, 1, 0, 10'h0);
      setin(1, 1, 1, 0, 10'h0);
      settle();
      chk("limit_infl0", io_inflight_0, 4);
      chk("limit_skip_valid", io_out_valid, 1);
      chk("limit_skip_grant", io_out_bits_source[9], 1);
      chk("limit_in0_ready", io_in_0_ready, 0);
      model_check();
      adv();
      setin(1, 0, 1, 1, 10'h012);
      settle();
      chk("limit_blocked", io_out_valid, 0);
      model_check();
      adv();
      setin(1, 0, 1, 0, 10'h0);
      settle();
      chk("limit_reopen_valid", io_out_valid, 1);
      chk("limit_reopen_grant", io_out_bits_source[9], 0);
      model_check();
      adv();

      // ack to an idle client
      do_reset();
      cyc(0, 0, 0, 1, 10'h200);
      setin(0, 0, 0, 0, 10'h0);
      settle();
      chk("underflow_err", io_err, 1);
      chk("underflow_infl1", io_inflight_1, 0);
      model_check();
      adv();

      // held client drops valid; error is sticky
      do_reset();
      cyc(1, 0, 0, 0, 10'h0);
      setin(0, 1, 0, 0, 10'h0);
      settle();
      chk("drop_valid", io_out_valid, 0);
      chk("drop_err_pre", io_err, 0);
      model_check();
      adv();
      setin(0, 1, 0, 0, 10'h0);
      settle();
      chk("drop_err", io_err, 1);
      chk("drop_unlock_valid", io_out_valid, 1);
      chk("drop_unlock_grant", io_out_bits_source[9], 1);
      model_check();
      adv();
      repeat (3) cyc(1, 1, 1, 0, 10'h0);
      setin(0, 0, 0, 0, 10'h0);
      settle();
      chk("err_sticky", io_err, 1);
      model_check();
      adv();

      // reset while held with counts and error set
      do_reset();
      repeat (3) cyc(1, 0, 1, 0, 10'h0);
      cyc(1, 0, 0, 1, 10'h200);
      setin(1, 0, 0, 0, 10'h0);
      settle();
      chk("prerst_infl0", io_inflight_0, 3);
      chk("prerst_err", io_err, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      setin(1, 1, 1, 0, 10'h0);
      settle();
      chk("rst_infl0", io_inflight_0, 0);
      chk("rst_infl1", io_inflight_1, 0);
      chk("rst_err", io_err, 0);
      chk("rst_tie_valid", io_out_valid, 1);
      chk("rst_tie_grant", io_out_bits_source[9], 0);
      model_check();
      adv();

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int c;
         bit av;
         rand_fields();
         c  = int'($urandom_range(0, 1));
         av = (m_infl[c] > 0) && ($urandom_range(0, 9) < 4);
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
             av, {c[0], 9'($urandom)});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
